// File: rtl/phy_manager_rx_if.sv
// Decoded-symbol input bus and flit output bus of the RX PHY manager.
// master: decoder side / endpoint side driver; slave: phy_manager_rx.
interface phy_manager_rx_if #(
   parameter int FLIT_W = 32
);
   logic              sym_valid;
   logic              sym_is_comma;
   logic [2:0]        sym_comma_type;
   logic [FLIT_W-1:0] sym_data;
   logic              sym_err;

   logic [FLIT_W-1:0] flit_out;
   logic              flit_sop;
   logic              flit_eop;
   logic              flit_valid;
   logic              flit_ready;

   modport master (
      output sym_valid,
      output sym_is_comma,
      output sym_comma_type,
      output sym_data,
      output sym_err,
      output flit_ready,
      input  flit_out,
      input  flit_sop,
      input  flit_eop,
      input  flit_valid
   );

   modport slave (
      input  sym_valid,
      input  sym_is_comma,
      input  sym_comma_type,
      input  sym_data,
      input  sym_err,
      input  flit_ready,
      output flit_out,
      output flit_sop,
      output flit_eop,
      output flit_valid
   );
endinterface

// File: rtl/phy_manager_rx.sv
// RX PHY manager: splits link-control commas into pulses and frames
// START/DATA/END symbols into SOP/EOP flits held in a FIFO.
// Ports: CLK, RST (sync, active-high); rx (slave) symbol in / flit out;
// ack_rx/nack_rx/grtcred0_rx/grtcred1_rx/pkt_err pulses; rx_overflow
// sticky, cleared by clear_err; fifo_count occupancy; pkt_count packets.
module phy_manager_rx #(
   parameter int FLIT_W     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   phy_manager_rx_if.slave             rx,
   output logic                        ack_rx,
   output logic                        nack_rx,
   output logic                        grtcred0_rx,
   output logic                        grtcred1_rx,
   output logic                        pkt_err,
   output logic                        rx_overflow,
   input  logic                        clear_err,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [CNT_W-1:0]            pkt_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = FLIT_W + 2;

   localparam logic [2:0] T_START = 3'd1;
   localparam logic [2:0] T_END   = 3'd2;
   localparam logic [2:0] T_ACK   = 3'd3;
   localparam logic [2:0] T_NACK  = 3'd4;
   localparam logic [2:0] T_GC0   = 3'd5;
   localparam logic [2:0] T_GC1   = 3'd6;

   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PKT,
      S_DROP
   } state_t;

   state_t              state_q, state_d;
   logic                stg_full_q, stg_full_d;
   logic [FLIT_W-1:0]   stg_data_q, stg_data_d;
   logic                stg_sop_q, stg_sop_d;
   logic                sop_nxt_q, sop_nxt_d;

   logic                ack_q, nack_q, gc0_q, gc1_q;
   logic                perr_q, perr_d;
   logic                ovf_q, ovf_d;
   logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;

   logic [EW-1:0]       mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic                sym_bad;
   logic                sym_ok;
   logic                is_ctl;
   logic                is_start;
   logic                is_end;
   logic                is_data;

   logic                push;
   logic [FLIT_W-1:0]   push_data;
   logic                push_sop;
   logic                push_eop;
   logic                end_pkt;
   logic                full;
   logic                pop;
   logic                ovf;
   logic                wr_en;
   logic [EW-1:0]       head;

   // Symbol classification; a coding error overrides the symbol type.
   assign sym_bad  = rx.sym_valid & rx.sym_err;
   assign sym_ok   = rx.sym_valid & ~rx.sym_err;
   assign is_ctl   = sym_ok & rx.sym_is_comma;
   assign is_start = is_ctl & (rx.sym_comma_type == T_START);
   assign is_end   = is_ctl & (rx.sym_comma_type == T_END);
   assign is_data  = sym_ok & ~rx.sym_is_comma;

   assign full = (cnt_q == FULL_CNT);
   assign pop  = rx.flit_valid & rx.flit_ready;

   // Framing FSM: next state, staging register and push request.
   always_comb begin
      state_d    = state_q;
      stg_full_d = stg_full_q;
      stg_data_d = stg_data_q;
      stg_sop_d  = stg_sop_q;
      sop_nxt_d  = sop_nxt_q;
      push       = 1'b0;
      push_data  = stg_data_q;
      push_sop   = stg_sop_q;
      push_eop   = 1'b0;
      end_pkt    = 1'b0;
      perr_d     = 1'b0;
      ovf        = 1'b0;

      unique case (1'b1)
         sym_bad: begin
            perr_d     = 1'b1;
            stg_full_d = 1'b0;
            sop_nxt_d  = 1'b0;
            state_d    = S_IDLE;
         end
         is_start: begin
            perr_d     = (state_q == S_PKT);
            stg_full_d = 1'b0;
            sop_nxt_d  = 1'b1;
            state_d    = S_PKT;
         end
         is_data: begin
            case (state_q)
               S_PKT: begin
                  push       = stg_full_q;
                  stg_full_d = 1'b1;
                  stg_data_d = rx.sym_data;
                  stg_sop_d  = sop_nxt_q;
                  sop_nxt_d  = 1'b0;
               end
               S_IDLE:  perr_d = 1'b1;
               default: ;
            endcase
         end
         is_end: begin
            case (state_q)
               S_PKT: begin
                  push       = stg_full_q;
                  push_eop   = 1'b1;
                  end_pkt    = stg_full_q;
                  perr_d     = ~stg_full_q;
                  stg_full_d = 1'b0;
                  sop_nxt_d  = 1'b0;
                  state_d    = S_IDLE;
               end
               S_IDLE:  perr_d  = 1'b1;
               default: state_d = S_IDLE;
            endcase
         end
         default: ;
      endcase

      // A push the FIFO cannot absorb abandons the rest of the packet.
      ovf = push & full & ~pop;
      if (ovf) begin
         state_d    = S_DROP;
         stg_full_d = 1'b0;
         sop_nxt_d  = 1'b0;
      end
   end

   assign wr_en = push & ~ovf;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      pkt_cnt_d = pkt_cnt_q;
      ovf_d     = ovf_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({wr_en, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      if (end_pkt & ~ovf) begin
         pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
      // A fresh overflow beats a simultaneous clear.
      if (ovf) begin
         ovf_d = 1'b1;
      end else if (clear_err) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         stg_full_q <= 1'b0;
         stg_data_q <= '0;
         stg_sop_q  <= 1'b0;
         sop_nxt_q  <= 1'b0;
         ack_q      <= 1'b0;
         nack_q     <= 1'b0;
         gc0_q      <= 1'b0;
         gc1_q      <= 1'b0;
         perr_q     <= 1'b0;
         ovf_q      <= 1'b0;
         pkt_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         stg_full_q <= stg_full_d;
         stg_data_q <= stg_data_d;
         stg_sop_q  <= stg_sop_d;
         sop_nxt_q  <= sop_nxt_d;
         ack_q      <= is_ctl & (rx.sym_comma_type == T_ACK);
         nack_q     <= is_ctl & (rx.sym_comma_type == T_NACK);
         gc0_q      <= is_ctl & (rx.sym_comma_type == T_GC0);
         gc1_q      <= is_ctl & (rx.sym_comma_type == T_GC1);
         perr_q     <= perr_d;
         ovf_q      <= ovf_d;
         pkt_cnt_q  <= pkt_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {push_data, push_sop, push_eop};
      end
   end

   assign head = mem_q[rd_ptr_q];

   assign rx.flit_out   = head[EW-1:2];
   assign rx.flit_sop   = head[1];
   assign rx.flit_eop   = head[0];
   assign rx.flit_valid = (cnt_q != '0);

   assign ack_rx      = ack_q;
   assign nack_rx     = nack_q;
   assign grtcred0_rx = gc0_q;
   assign grtcred1_rx = gc1_q;
   assign pkt_err     = perr_q;
   assign rx_overflow = ovf_q;
   assign fifo_count  = cnt_q;
   assign pkt_count   = pkt_cnt_q;
endmodule
